psum_requant: RTL

//  Downstream end of the MAC psum path. Consumes the signed psums the PE column emits, one per beat.

---
 rtl/psum_requant.sv | 139 +++++++++++++
 1 files changed

// File: rtl/psum_requant.sv
// psum_requant: the downstream end of the MAC psum path.
// It accumulates NUM_ACC signed psums into one output pixel. It then applies ReLU,
// an arithmetic right shift and unsigned saturation, and produces an ACT_BW-bit activation.
// Optional feature macro: PSUM_REQUANT_ROUND_EN. When it is defined, the block rounds
// half-up before the shift.
module psum_requant #(
    parameter int PSUM_BW = 16,
    parameter int ACT_BW  = 4,
    parameter int ACC_BW  = 20,
    parameter int NUM_ACC = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [3:0]         shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PSUM_BW-1:0] in_psum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACT_BW-1:0]  out_act,
    output logic               busy
);

    localparam int CNT_BW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(NUM_ACC - 1);
    localparam logic [ACC_BW:0] MAX_ACT = (ACC_BW + 1)'((1 << ACT_BW) - 1);

    typedef enum logic {
        ACCUM,
        EMIT
    } state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_BW-1:0]  acc, acc_nxt;
    logic [CNT_BW-1:0]         count, count_nxt;
    logic                      valid_nxt;
    logic [ACT_BW-1:0]         act_nxt;
    logic signed [ACC_BW-1:0]  psum_ext;
    logic signed [ACC_BW-1:0]  sum;

    // Convert a final accumulator value into an activation.
    // Negative values clamp to zero. The value is optionally rounded, shifted,
    // and then saturated to the activation range.
    function automatic logic [ACT_BW-1:0] requant(input logic signed [ACC_BW-1:0] s,
                                                   input logic [3:0] sh);
        logic [ACC_BW:0] t;
        logic [ACC_BW:0] r;
        if (s[ACC_BW-1]) begin
            return '0;
        end
        t = {1'b0, s};
`ifdef PSUM_REQUANT_ROUND_EN
        if (sh != 4'd0) begin
            t = t + ((ACC_BW + 1)'(1) << (sh - 4'd1));
        end
`endif
        r = t >> sh;
        if (r > MAX_ACT) begin
            return '1;
        end
        return r[ACT_BW-1:0];
    endfunction

    assign psum_ext = ACC_BW'(signed'(in_psum));
    assign sum      = acc + psum_ext;
    assign in_ready = (state == ACCUM) | out_ready;
    assign busy     = (count != '0) | out_valid;

    // Next-state logic for the accumulate/emit controller and its datapath.
    // clear overrides everything else.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        valid_nxt = out_valid;
        act_nxt   = out_act;
        if (clear) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            count_nxt = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (count == LAST_CNT) begin
                            act_nxt   = requant(sum, shift);
                            valid_nxt = 1'b1;
                            acc_nxt   = '0;
                            count_nxt = '0;
                            state_nxt = EMIT;
                        end else begin
                            acc_nxt   = sum;
                            count_nxt = count + CNT_BW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_nxt = 1'b0;
                        state_nxt = ACCUM;
                        if (in_valid) begin
                            if (NUM_ACC == 1) begin
                                act_nxt   = requant(psum_ext, shift);
                                valid_nxt = 1'b1;
                                state_nxt = EMIT;
                            end else begin
                                acc_nxt   = psum_ext;
                                count_nxt = CNT_BW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ACCUM;
                end
            endcase
        end
    end

    // State and datapath registers, returned to idle by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_act   <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            out_valid <= valid_nxt;
            out_act   <= act_nxt;
        end
    end

endmodule
